usb_rx_ctrl: RTL and testbench

Receive control unit for the USB 1.1 full-speed receiver. It sequences each incoming packet: SYNC check, PID capture, then data-byte storage.
- It drives the PID holding register's pid_set/pid_rst/pid_in and consumes that register's pid_err flag.
- It enables FIFO writes and reports receive errors.
- It sits between the shift register/EOP detector and the PID register and RX FIFO.

---
 rtl/usb_rx_ctrl.sv | 126 ++++++++++++
 tb/tb_usb_rx_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_ctrl.sv
// USB 1.1 full-speed receive control: SYNC check, PID capture, data-byte store into RX FIFO.
// Moore strobes decoded from state; pid_in, r_error and byte_cnt registered.
module usb_rx_ctrl #(
  parameter int         MAX_BYTES = 66,
  parameter logic [7:0] SYNC_BYTE = 8'h80
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic       pid_err,
  output logic       pid_set,
  output logic       pid_rst,
  output logic [3:0] pid_in,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error
);

  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BYTES);

  typedef enum logic [3:0] {
    IDLE, CLR, SYNC_WAIT, SYNC_CHK, PID_WAIT, PID_CHK, PID_LOAD, PID_VAL,
    DATA_WAIT, STORE, EOP_WAIT, ERR_EOP, ERR_IDLE
  } state_t;

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic          eop_s;

  assign eop_s = eop & shift_enable;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      pid_in   <= 4'h0;
      r_error  <= 1'b0;
      byte_cnt <= '0;
    end else begin
      case (state)
        IDLE:      if (d_edge) state <= CLR;
        CLR: begin
          r_error  <= 1'b0;
          byte_cnt <= '0;
          state    <= SYNC_WAIT;
        end
        // eop_s takes priority over a coincident byte in every wait state
        SYNC_WAIT: begin
          if (eop_s) begin
            r_error <= 1'b1;
            state   <= ERR_IDLE;
          end else if (byte_received) begin
            state <= SYNC_CHK;
          end
        end
        SYNC_CHK: begin
          if (rcv_data == SYNC_BYTE) begin
            state <= PID_WAIT;
          end else begin
            r_error <= 1'b1;
            state   <= ERR_EOP;
          end
        end
        PID_WAIT: begin
          if (eop_s) begin
            r_error <= 1'b1;
            state   <= ERR_IDLE;
          end else if (byte_received) begin
            state <= PID_CHK;
          end
        end
        PID_CHK: begin
          if (rcv_data[7:4] == ~rcv_data[3:0]) begin
            pid_in <= rcv_data[3:0];
            state  <= PID_LOAD;
          end else begin
            r_error <= 1'b1;
            state   <= ERR_EOP;
          end
        end
        PID_LOAD:  state <= PID_VAL;
        PID_VAL: begin
          if (pid_err) begin
            r_error <= 1'b1;
            state   <= ERR_EOP;
          end else begin
            state <= DATA_WAIT;
          end
        end
        DATA_WAIT: begin
          if (eop_s) begin
            state <= EOP_WAIT;
          end else if (byte_received) begin
            if (byte_cnt == CNT_MAX) begin
              r_error <= 1'b1;
              state   <= ERR_EOP;
            end else begin
              state <= STORE;
            end
          end
        end
        STORE: begin
          if (byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + 1'b1;
          state <= DATA_WAIT;
        end
        EOP_WAIT:  if (d_edge) state <= IDLE;
        ERR_EOP: begin
          r_error <= 1'b1;
          if (eop_s) state <= ERR_IDLE;
        end
        ERR_IDLE:  if (d_edge) state <= CLR;
        default:   state <= IDLE;
      endcase
    end
  end

  assign pid_rst  = (state == CLR);
  assign pid_set  = (state == PID_LOAD);
  assign w_enable = (state == STORE);
  assign rcving   = (state != IDLE) && (state != CLR) && (state != ERR_IDLE);

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl; a small PID-register model supplies pid_err.
module tb_usb_rx_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_edge = 1'b0, eop = 1'b0, shift_enable = 1'b0, byte_received = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic       pid_err;
  logic       pid_set, pid_rst, rcving, w_enable, r_error;
  logic [3:0] pid_in;

  int vectors = 0;
  int miscompares = 0;
  int w_cnt = 0, set_cnt = 0, rst_cnt = 0;
  int w_base, set_base, rst_base;
  logic [3:0] pid_reg;

  always #5 clk = ~clk;

  usb_rx_ctrl #(.MAX_BYTES(66), .SYNC_BYTE(8'h80)) dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop), .shift_enable(shift_enable),
    .byte_received(byte_received), .rcv_data(rcv_data), .pid_err(pid_err),
    .pid_set(pid_set), .pid_rst(pid_rst), .pid_in(pid_in), .rcving(rcving),
    .w_enable(w_enable), .r_error(r_error)
  );

  // Model of the PID holding register the controller drives
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) pid_reg <= 4'hF;
    else if (pid_rst) pid_reg <= 4'hF;
    else if (pid_set) pid_reg <= pid_in;
  end

  always_comb begin
    case (pid_reg)
      4'h1, 4'h9, 4'h5, 4'hD, 4'h3, 4'hB, 4'h2, 4'hA, 4'hE, 4'hC: pid_err = 1'b0;
      default: pid_err = 1'b1;
    endcase
  end

  always @(posedge clk) begin
    if (w_enable) w_cnt++;
    if (pid_set)  set_cnt++;
    if (pid_rst)  rst_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mark();
    w_base = w_cnt; set_base = set_cnt; rst_base = rst_cnt;
  endtask

  // d_edge into CLR, then one more cycle lands in SYNC_WAIT
  task automatic start_pkt();
    mark();
    d_edge = 1'b1; tick(); d_edge = 1'b0;
    tick();
  endtask

  // Byte strobe plus the following cycle (CHK state or STORE->DATA_WAIT)
  task automatic byte_in(input logic [7:0] b);
    rcv_data = b; byte_received = 1'b1; tick(); byte_received = 1'b0;
    tick();
  endtask

  task automatic eop_pulse();
    eop = 1'b1; shift_enable = 1'b1; tick(); eop = 1'b0; shift_enable = 1'b0;
  endtask

  task automatic edge_pulse();
    d_edge = 1'b1; tick(); d_edge = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_pid_set", pid_set, 0);
    check("rst_pid_rst", pid_rst, 0);
    check("rst_pid_in", pid_in, 0);
    check("rst_rcving", rcving, 0);
    check("rst_w_enable", w_enable, 0);
    check("rst_r_error", r_error, 0);
    tick(); n_rst = 1'b1; tick();

    // 1: token packet
    mark();
    d_edge = 1'b1; tick(); d_edge = 1'b0;
    check("t1_pid_rst_in_clr", pid_rst, 1);
    tick();
    check("t1_rcving_sync_wait", rcving, 1);
    byte_in(8'h80);
    byte_in(8'hE1);
    check("t1_pid_set", pid_set, 1);
    check("t1_pid_in", pid_in, 4'h1);
    tick(); tick();
    eop_pulse();
    check("t1_rcving_eop_wait", rcving, 1);
    edge_pulse();
    check("t1_rcving_after_edge", rcving, 0);
    check("t1_pid_rst_count", 8'(rst_cnt - rst_base), 1);
    check("t1_pid_set_count", 8'(set_cnt - set_base), 1);
    check("t1_no_write", 8'(w_cnt - w_base), 0);
    check("t1_r_error", r_error, 0);

    // 2: data packet, w_enable is sampled high at the 2nd rising edge after the strobe launches
    start_pkt();
    byte_in(8'h80); byte_in(8'hC3); tick(); tick();
    check("t2_pid_in", pid_in, 4'h3);
    for (int i = 0; i < 3; i++) begin
      rcv_data = 8'(8'h10 + i); byte_received = 1'b1;
      check("t2_w_before", w_enable, 0);
      tick(); byte_received = 1'b0;
      check("t2_w_store", w_enable, 1);
      tick();
      check("t2_w_after", w_enable, 0);
    end
    eop_pulse(); edge_pulse();
    check("t2_write_count", 8'(w_cnt - w_base), 3);
    check("t2_r_error", r_error, 0);

    // 3: bad SYNC
    start_pkt();
    byte_in(8'h81);
    check("t3_r_error", r_error, 1);
    check("t3_rcving_err_eop", rcving, 1);
    eop_pulse();
    check("t3_r_error_sticky", r_error, 1);
    check("t3_rcving_err_idle", rcving, 0);
    check("t3_no_pid_set", 8'(set_cnt - set_base), 0);
    edge_pulse(); tick();
    check("t3_r_error_cleared", r_error, 0);
    eop_pulse();

    // 4a: check-field mismatch
    start_pkt();
    byte_in(8'h80); byte_in(8'hF1);
    check("t4a_r_error", r_error, 1);
    check("t4a_no_pid_set", 8'(set_cnt - set_base), 0);
    eop_pulse();

    // 4b: complement valid but PID undefined
    start_pkt();
    byte_in(8'h80); byte_in(8'h87);
    check("t4b_pid_set", pid_set, 1);
    tick();
    check("t4b_pid_err", pid_err, 1);
    check("t4b_r_error_pre", r_error, 0);
    tick();
    check("t4b_r_error", r_error, 1);
    byte_in(8'h55);
    eop_pulse();
    check("t4b_no_write", 8'(w_cnt - w_base), 0);
    check("t4b_pid_in", pid_in, 4'h7);

    // 5: overflow, MAX_BYTES+1 data bytes
    start_pkt();
    byte_in(8'h80); byte_in(8'h4B); tick(); tick();
    for (int i = 0; i < 66; i++) byte_in(8'(i));
    check("t5_r_error_pre", r_error, 0);
    rcv_data = 8'hEE; byte_received = 1'b1; tick(); byte_received = 1'b0;
    check("t5_extra_no_w", w_enable, 0);
    check("t5_r_error", r_error, 1);
    tick();
    eop_pulse();
    check("t5_write_count", 8'(w_cnt - w_base), 66);

    // 6a: early EOP while waiting for the PID
    start_pkt();
    byte_in(8'h80);
    eop_pulse();
    check("t6a_r_error", r_error, 1);
    check("t6a_rcving", rcving, 0);

    // 6b: asynchronous reset during STORE
    start_pkt();
    byte_in(8'h80); byte_in(8'hC3); tick(); tick();
    rcv_data = 8'hA5; byte_received = 1'b1; tick(); byte_received = 1'b0;
    check("t6b_in_store", w_enable, 1);
    mark();
    #2 n_rst = 1'b0; #1;
    check("t6b_w_enable", w_enable, 0);
    check("t6b_rcving", rcving, 0);
    check("t6b_pid_in", pid_in, 0);
    check("t6b_r_error", r_error, 0);
    check("t6b_pid_set", pid_set, 0);
    check("t6b_pid_rst", pid_rst, 0);
    tick(); tick(); n_rst = 1'b1; tick(); tick();
    check("t6b_no_write", 8'(w_cnt - w_base), 0);
    check("t6b_stays_idle", rcving, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
